// File: rtl/rob_pkg.sv
// Shared widths, entry layout and FSM encoding for the reorder buffer.
package rob_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int TAG_W_DEF  = 4;
  localparam int PREG_W_DEF = 6;
  localparam int AREG_W_DEF = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_dest;
    logic                  mem_op;
    logic                  halt;
    logic [AREG_W_DEF-1:0] arch_rd;
    logic [PREG_W_DEF-1:0] new_preg;
    logic [PREG_W_DEF-1:0] old_preg;
  } rob_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } rob_state_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular ROB: one dispatch and one in-order retire per cycle, one squashed entry per cycle during recovery.
// Commit is combinational from the registered head; dispatch stalls on ROB_full or stall_recover.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int AREG_W = AREG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isDispatch,
  input  logic              MemOp,
  input  logic              RegDest,
  input  logic              halt,
  input  logic [AREG_W-1:0] arch_rd,
  input  logic [PREG_W-1:0] new_preg,
  input  logic [PREG_W-1:0] old_preg,
  output logic [TAG_W-1:0]  rob_tag,
  output logic              ROB_full,
  input  logic              cmplt_valid,
  input  logic [TAG_W-1:0]  cmplt_tag,
  input  logic              mispred_valid,
  input  logic [TAG_W-1:0]  mispred_tag,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_arch_rd,
  output logic [PREG_W-1:0] commit_preg,
  output logic [PREG_W-1:0] commit_old_preg,
  output logic              commit_RegDest,
  output logic              commit_MemOp,
  output logic              commit_halt,
  output logic              stall_recover,
  output logic              recover_valid,
  output logic [AREG_W-1:0] recover_arch_rd,
  output logic [PREG_W-1:0] recover_preg,
  output logic [PREG_W-1:0] recover_old_preg,
  output logic              recover_RegDest
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

  rob_entry_t rob_q [DEPTH];
  rob_entry_t rob_d [DEPTH];

  rob_state_t       state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] stop_q, stop_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             halted_q, halted_d;

  logic             is_idle;
  logic             disp_ok;
  logic             commit_ok;
  logic [TAG_W-1:0] tail_m1;

  assign is_idle       = (state_q == IDLE);
  assign ROB_full      = (count_q == FULL_CNT);
  assign rob_tag       = tail_q;
  assign stall_recover = (state_q == RECOVER);
  assign tail_m1       = tail_q - ONE_TAG;
  assign disp_ok       = isDispatch & ~ROB_full & is_idle & ~mispred_valid;
  assign commit_ok     = is_idle & (count_q != '0) & rob_q[head_q].done & ~halted_q;

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    tail_d           = tail_q;
    stop_d           = stop_q;
    count_d          = count_q;
    halted_d         = halted_q;
    rob_d            = rob_q;
    commit_valid     = 1'b0;
    commit_arch_rd   = '0;
    commit_preg      = '0;
    commit_old_preg  = '0;
    commit_RegDest   = 1'b0;
    commit_MemOp     = 1'b0;
    commit_halt      = 1'b0;
    recover_valid    = 1'b0;
    recover_arch_rd  = '0;
    recover_preg     = '0;
    recover_old_preg = '0;
    recover_RegDest  = 1'b0;

    // Completions for squashed or retired slots land on invalid entries and are dropped.
    if (cmplt_valid && rob_q[cmplt_tag].valid) begin
      rob_d[cmplt_tag].done = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (commit_ok) begin
          commit_valid    = 1'b1;
          commit_arch_rd  = rob_q[head_q].arch_rd;
          commit_preg     = rob_q[head_q].new_preg;
          commit_old_preg = rob_q[head_q].old_preg;
          commit_RegDest  = rob_q[head_q].reg_dest;
          commit_MemOp    = rob_q[head_q].mem_op;
          commit_halt     = rob_q[head_q].halt;
          rob_d[head_q].valid = 1'b0;
          head_d          = head_q + ONE_TAG;
          if (rob_q[head_q].halt) begin
            halted_d = 1'b1;
          end
        end
        if (disp_ok) begin
          rob_d[tail_q].valid    = 1'b1;
          rob_d[tail_q].done     = 1'b0;
          rob_d[tail_q].reg_dest = RegDest;
          rob_d[tail_q].mem_op   = MemOp;
          rob_d[tail_q].halt     = halt;
          rob_d[tail_q].arch_rd  = arch_rd;
          rob_d[tail_q].new_preg = new_preg;
          rob_d[tail_q].old_preg = old_preg;
          tail_d                 = tail_q + ONE_TAG;
        end
        count_d = count_q + {{TAG_W{1'b0}}, disp_ok} - {{TAG_W{1'b0}}, commit_ok};
        if (mispred_valid) begin
          state_d = RECOVER;
          stop_d  = mispred_tag;
        end
      end
      RECOVER: begin
        // Walk back youngest-first until the entry just after the branch has been squashed.
        if (tail_q == stop_q + ONE_TAG) begin
          state_d = IDLE;
        end else begin
          recover_valid        = 1'b1;
          recover_arch_rd      = rob_q[tail_m1].arch_rd;
          recover_preg         = rob_q[tail_m1].new_preg;
          recover_old_preg     = rob_q[tail_m1].old_preg;
          recover_RegDest      = rob_q[tail_m1].reg_dest;
          rob_d[tail_m1].valid = 1'b0;
          tail_d               = tail_m1;
          count_d              = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      stop_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      rob_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      stop_q   <= stop_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      rob_q    <= rob_d;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order pipe.
- Accepts one dispatched instruction per cycle from the decode/dispatch stage and returns its ROB tag.
- Marks entries done on completion broadcast and retires them strictly in program order, at most one per cycle.
- Squashes younger entries after a branch mispredict by walking back from the tail, so rename state can be restored.
- Drives the `ROB_full` and `stall_recover` signals that dispatch consumes.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; must be a power of two.
- `TAG_W`, 4, log2(`DEPTH`).
- `PREG_W`, 6, physical register tag width.
- `AREG_W`, 5, architectural register index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `isDispatch`  in  1  dispatch request.
- `MemOp`  in  1  instruction is a memory operation.
- `RegDest`  in  1  instruction writes a register.
- `halt`  in  1  instruction is a halt.
- `arch_rd`  in  `AREG_W`  destination architectural register.
- `new_preg`  in  `PREG_W`  newly allocated physical register.
- `old_preg`  in  `PREG_W`  previous mapping of `arch_rd`.
- `rob_tag`  out  `TAG_W`  tag of the next entry to be allocated (equals `tail`).
- `ROB_full`  out  1  all `DEPTH` entries occupied.
- `cmplt_valid`  in  1  completion broadcast.
- `cmplt_tag`  in  `TAG_W`  tag of the completing entry.
- `mispred_valid`  in  1  branch mispredict.
- `mispred_tag`  in  `TAG_W`  tag of the mispredicted branch.
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_arch_rd`  out  `AREG_W`  `arch_rd` of the retiring entry.
- `commit_preg`  out  `PREG_W`  `new_preg` of the retiring entry.
- `commit_old_preg`  out  `PREG_W`  `old_preg` of the retiring entry.
- `commit_RegDest`  out  1  `RegDest` of the retiring entry.
- `commit_MemOp`  out  1  `MemOp` of the retiring entry.
- `commit_halt`  out  1  retiring entry is a halt.
- `stall_recover`  out  1  recovery walk in progress.
- `recover_valid`  out  1  one squashed entry is presented this cycle.
- `recover_arch_rd`  out  `AREG_W`  `arch_rd` of the squashed entry.
- `recover_preg`  out  `PREG_W`  `new_preg` of the squashed entry.
- `recover_old_preg`  out  `PREG_W`  `old_preg` of the squashed entry.
- `recover_RegDest`  out  1  `RegDest` of the squashed entry.

## Operation
State:
- Entry fields: `valid`, `done`, `RegDest`, `MemOp`, `halt`, `arch_rd`, `new_preg`, `old_preg`.
- Registers `head`, `tail` (`TAG_W` bits, wrap modulo `DEPTH`), `count` (`TAG_W`+1 bits), `halted`, `stop` tag, and FSM state IDLE / RECOVER.

Derived signals:
- `ROB_full` = (`count` == `DEPTH`). `rob_tag` = `tail`.
- `disp_ok` = `isDispatch` & !`ROB_full` & IDLE & !`mispred_valid`. When set: write the entry at `tail` with `valid`=1, `done`=0, then `tail`++.
- `commit_ok` = IDLE & `count`≠0 & `done[head]` & !`halted`. When set: all `commit_*` outputs are driven combinationally from the head entry; `valid[head]` is cleared and `head`++.
- A retiring halt entry sets `halted`. `halted` is sticky until reset; no further commits.

Completion:
- `cmplt_valid` sets `done[cmplt_tag]` only if `valid[cmplt_tag]`; otherwise it is ignored.
- Completion is accepted in both FSM states.

Count update in IDLE: `count` ← `count` + `disp_ok` − `commit_ok`.

Recovery FSM:
- IDLE → RECOVER on `mispred_valid`; `stop` ← `mispred_tag`.
- A commit in the same cycle still happens, including when the branch itself is at the head.
- `mispred_valid` while in RECOVER is ignored.
- RECOVER, each cycle:
  - If `tail` == `stop`+1: go to IDLE, with no output.
  - Otherwise: `recover_valid`=1 with the fields of entry `tail`−1; clear its `valid`; `tail`−−; `count`−−.
- `stall_recover` = (state == RECOVER). Dispatch and commit are blocked throughout.

## Timing
- Reset values: all outputs 0; `head`=`tail`=`count`=0; all `valid` bits 0; `halted`=0; state IDLE.
- Reset mid-walk returns to IDLE immediately.
- Dispatch-to-tag: `rob_tag` is valid in the request cycle; the entry is allocated at that edge.
- Completion-to-commit: at least 1 cycle. An entry completing at cycle n commits no earlier than cycle n+1, since commit reads the registered `done` bit.
- Full boundary:
  - `ROB_full` is derived from registered `count`. At full, a commit and a dispatch request in the same cycle do not allocate; `ROB_full` drops the next cycle.
- Recovery duration: k+1 cycles for k younger entries. `stall_recover` is high for all of them; `recover_valid` is high for the first k, youngest first.
- Pointer wrap: `DEPTH`−1 → 0 on increment; 0 → `DEPTH`−1 on the recovery decrement.

## Structure
- Package `rob_pkg` holds:
  - the `DEPTH`, `TAG_W`, `PREG_W`, `AREG_W` defaults;
  - the `rob_entry_t` struct;
  - the `rob_state_t` enum {IDLE, RECOVER}.
- Single module; the entry array is an inline flop array. No sub-module.

## Test plan
- Reset, then 17 back-to-back dispatches: tags 0..15 are issued; `ROB_full`=1 after the 16th; the 17th is not allocated (`tail` stays 0).
- Dispatch tags 0,1,2; complete 2, then 1: no commit. Complete 0: `commit_valid` for tags 0,1,2 on three consecutive cycles.
- Dispatch tags 0..5; `mispred_tag`=2: `stall_recover` high 4 cycles; `recover_valid` presents tags 5,4,3 in order; afterwards `rob_tag`=3 and `count`=3.
- Wrap: `head`=14, entries at 14,15,0,1; `mispred_tag`=14: squashes 1,0,15 in order; `tail` ends at 15.
- Full ROB, head done, `isDispatch`=1: one commit, no allocation, `count`=15, `ROB_full`=0 next cycle.
- Halt at tag 3, tags 3..5 all done: tag 3 commits with `commit_halt`=1; tags 4 and 5 never commit.
